alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Time-shares the single combinational ALU between NREQ requesters (e.g. main datapath and a branch/address helper) using valid/ready handshakes.
- Grants round-robin, latches the operands, drives the ALU for one execute cycle, and registers the result.
- Returns the result to the granted requester and holds it until that requester accepts it.
- Sits between the requesters and the ALU instance; it owns the ALU's operand and op inputs.

Parameters:
- WIDTH, 32, operand/result width in bits.
- NREQ, 2, number of requesters (2..8).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  requester i has an operation pending.
- req_ready  out  NREQ  one-hot; operation i accepted this cycle.
- req_a  in  NREQ*WIDTH  operand A of requester i, slice [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B, same slicing.
- req_op  in  NREQ*4  ALU op code, slice [i*4 +: 4].
- resp_valid  out  NREQ  one-hot; result available for requester i.
- resp_ready  in  NREQ  requester i consumes its result.
- resp_data  out  WIDTH  registered result, shared by all requesters.
- resp_err  out  1  the returned op was illegal; qualified by any resp_valid.
- alu_a  out  WIDTH  to ALU operand A.
- alu_b  out  WIDTH  to ALU operand B.
- alu_op  out  4  to ALU op select.
- alu_res  in  WIDTH  from ALU result, combinational.

Behaviour:
- Legal op codes: 0000 ADD, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL, 0110 OR, 0111 AND, 1000 SUB, 1101 SRA. All other codes are illegal.
- Reset (async, rst=1) sets:
  - state=IDLE, last_grant=NREQ-1, so requester 0 wins first.
  - req_ready=0, resp_valid=0, resp_data=0, resp_err=0.
  - alu_a=0, alu_b=0, alu_op=0000.
- Reset mid-transaction drops the transaction silently; no response is ever produced for it.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is set, the round-robin pick is the first set bit searching from last_grant+1 upward with wrap-around.
  - req_ready[pick]=1 for exactly this cycle (a combinational function of req_valid and last_grant).
  - Latch a, b, op and owner=pick; go to EXEC.
  - If no req_valid is set, stay in IDLE; req_ready=0.
- EXEC:
  - alu_a/alu_b/alu_op are driven from the latched registers. In all other states they hold their last values.
  - For an illegal op: alu_op driven 0000, resp_data captures 0, resp_err captures 1.
  - Otherwise resp_data captures alu_res and resp_err captures 0.
  - Go to RESP; last_grant=owner.
- RESP:
  - resp_valid[owner]=1; resp_data/resp_err are stable.
  - When resp_ready[owner]=1, go to IDLE.
  - resp_ready on other indices is ignored.
- Latency and throughput:
  - Accept at cycle N, result visible at cycle N+2.
  - Minimum 3 cycles per transaction; back-to-back acceptance occurs in the IDLE cycle after the response handshake.
- Requesters must hold req_* stable while req_valid=1 and not yet accepted. A requester may deassert valid before acceptance; the arbiter only samples in IDLE.
- Simultaneous requests: exactly one grant per IDLE cycle. Losers keep waiting; the rotation guarantees each waits at most NREQ-1 transactions.
- A requester may re-request while its own response is pending. It is served only after the response handshake and the next arbitration.
- Widths: WIDTH is passed through unchanged; no width conversion; no overflow flags.

Decomposition:
- Package alu_pkg holds:
  - the 4-bit ALU op constants above as an enum typedef alu_op_t;
  - function is_legal_op(alu_op_t);
  - the FSM state typedef {IDLE, EXEC, RESP}.
- Sub-module rr_arbiter(NREQ): inputs req vector and last_grant; outputs a one-hot grant and the encoded index.
  - Purely combinational.
  - Reused later for memory-port sharing.

Test Plan:
- Reset with rst pulsed mid-EXEC (requester 0 ADD 5+7 in flight) -> all outputs 0, no resp_valid afterwards, next request 1+1 is served normally with resp_data=2.
- Single request: req0 SUB a=10, b=3 -> req_ready[0] at cycle N, resp_valid[0] at N+2 with resp_data=7, resp_err=0. Holding resp_ready=0 for 4 cycles keeps the data stable.
- Both requesters valid continuously: req0 ADD 1+2, req1 XOR 0xF0^0x0F -> grant order after reset is 0,1,0,1. Responses are 3 and 0xFF alternately; no requester is starved.
- Illegal op 1010 from req1 with a=0xFFFFFFFF -> alu_op=0000 during EXEC, resp_data=0, resp_err=1. The following legal SRA 0x80000000>>>4 returns 0xF8000000 with resp_err=0.
- Edge ops: SLTU 1 vs 0xFFFFFFFF, SLL 1<<31, SLT 0x80000000 vs 1 -> resp_data equals the ALU result of the corresponding op each time, transparently passed.
- resp_ready asserted on a non-owner index during RESP -> ignored; state remains RESP until the owner's resp_ready.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: ALU op codes, legality check and arbiter FSM states
package alu_pkg;
    localparam int OPW = 4;
    typedef enum logic [OPW-1:0] {
        OP_ADD  = 4'b0000,
        OP_SLL  = 4'b0001,
        OP_SLT  = 4'b0010,
        OP_SLTU = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_SRL  = 4'b0101,
        OP_OR   = 4'b0110,
        OP_AND  = 4'b0111,
        OP_SUB  = 4'b1000,
        OP_SRA  = 4'b1101
    } alu_op_t;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    function automatic logic is_legal_op(alu_op_t op);
        return op inside {OP_ADD, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
                          OP_SRL, OP_OR, OP_AND, OP_SUB, OP_SRA};
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting after the last grant
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] last,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] idx
);
    logic [NREQ-1:0] hi, pool;
    // prefer requesters above last, else wrap to the lowest; pick lowest set bit
    always_comb begin
        hi = '0;
        for (int i = 0; i < NREQ; i++) hi[i] = req[i] && (i > int'(last));
        pool = |hi ? hi : req;
        idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) if (pool[i]) idx = IDXW'(i);
        grant = pool & (~pool + NREQ'(1));
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin time-sharing of one combinational ALU among requesters
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREQ  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*4-1:0]     req_op,
    output logic [NREQ-1:0]       resp_valid,
    input  logic [NREQ-1:0]       resp_ready,
    output logic [WIDTH-1:0]      resp_data,
    output logic                  resp_err,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    output logic [3:0]            alu_op,
    input  logic [WIDTH-1:0]      alu_res
);
    localparam int IDXW = $clog2(NREQ);
    state_t          state;
    logic [IDXW-1:0] last_grant, owner, pick;
    logic [NREQ-1:0] grant;
    logic            err_q, pick_legal;
    logic [3:0]      pick_op;
    rr_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) u_rr (
        .req  (req_valid),
        .last (last_grant),
        .grant(grant),
        .idx  (pick)
    );
    assign pick_op    = req_op[pick*4 +: 4];
    assign pick_legal = is_legal_op(alu_op_t'(pick_op));
    assign req_ready  = (state == IDLE && !rst) ? grant : '0;
    assign resp_valid = state == RESP ? NREQ'(1) << owner : '0;
    // accept in IDLE straight into the ALU drive registers, capture result in EXEC, hold in RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= IDXW'(NREQ - 1);
            owner      <= '0;
            err_q      <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= OP_ADD;
        end else begin
            case (state)
                IDLE: if (|req_valid) begin
                    owner  <= pick;
                    alu_a  <= req_a[pick*WIDTH +: WIDTH];
                    alu_b  <= req_b[pick*WIDTH +: WIDTH];
                    alu_op <= pick_legal ? pick_op : OP_ADD;
                    err_q  <= !pick_legal;
                    state  <= EXEC;
                end
                EXEC: begin
                    resp_data  <= err_q ? '0 : alu_res;
                    resp_err   <= err_q;
                    last_grant <= owner;
                    state      <= RESP;
                end
                RESP: if (resp_ready[owner]) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: table, directed and random checks of alu_arbiter against a reference model
module tb_alu_arbiter;
    logic        clk = 1'b0, rst = 1'b1;
    logic [1:0]  req_valid = '0, req_ready, resp_valid, resp_ready = '0;
    logic [63:0] req_a = '0, req_b = '0;
    logic [7:0]  req_op = '0;
    logic [31:0] resp_data, alu_a, alu_b, alu_res;
    logic        resp_err;
    logic [3:0]  alu_op;
    int errors = 0, checks = 0;

    typedef struct {
        int          idx;
        logic [3:0]  op;
        logic [31:0] a, b, d;
        logic        e;
        int          hold;
    } vec_t;
    vec_t tbl[10];

    alu_arbiter #(.WIDTH(32), .NREQ(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(logic [31:0] a, logic [31:0] b, logic [3:0] op);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a << b[4:0];
            4'd2:  return {31'd0, $signed(a) < $signed(b)};
            4'd3:  return {31'd0, a < b};
            4'd4:  return a ^ b;
            4'd5:  return a >> b[4:0];
            4'd6:  return a | b;
            4'd7:  return a & b;
            4'd8:  return a - b;
            4'd13: return $unsigned($signed(a) >>> b[4:0]);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic bit legal(logic [3:0] op);
        return op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd13};
    endfunction

    assign alu_res = alu_f(alu_a, alu_b, alu_op);

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(int i, logic [3:0] op, logic [31:0] a, logic [31:0] b);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
        req_op[i*4 +: 4]  = op;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        resp_ready = '0;
        #3;
        check("rst_outputs", {resp_data ^ alu_a ^ alu_b, resp_err, alu_op, req_ready, resp_valid} == '0, 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int who);
        who = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (|req_ready) begin
                who = req_ready[1] ? 1 : 0;
                break;
            end
        end
        check("accept_seen", who >= 0, 1);
        if (who >= 0) check("ready_onehot", $countones(req_ready), 1);
        else who = 0;
    endtask

    task automatic finish_txn(int who, logic [3:0] op, logic [31:0] d, logic e, int hold, logic [1:0] drop);
        @(posedge clk);
        #1 req_valid = req_valid & ~drop;
        @(negedge clk);
        check("exec_alu_op", alu_op, legal(op) ? op : 4'd0);
        check("exec_no_resp", resp_valid, 0);
        @(negedge clk);
        check("resp_valid", resp_valid, 2'b01 << who);
        check("resp_data", resp_data, d);
        check("resp_err", resp_err, e);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", resp_valid, 2'b01 << who);
            check("hold_data", resp_data, d);
        end
        resp_ready[who] = 1'b1;
        @(posedge clk);
        #1 resp_ready = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int w, last, exp_w;
        logic [1:0]  mask;
        logic [3:0]  ops[2];
        logic [31:0] as[2], bs[2];
        logic        any_resp;
        tbl[0] = '{0, 4'd8,  32'd10,        32'd3,         32'd7,         1'b0, 4};
        tbl[1] = '{1, 4'd10, 32'hFFFF_FFFF, 32'd5,         32'd0,         1'b1, 0};
        tbl[2] = '{1, 4'd13, 32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0, 0};
        tbl[3] = '{0, 4'd3,  32'd1,         32'hFFFF_FFFF, 32'd1,         1'b0, 0};
        tbl[4] = '{1, 4'd1,  32'd1,         32'd31,        32'h8000_0000, 1'b0, 0};
        tbl[5] = '{0, 4'd2,  32'h8000_0000, 32'd1,         32'd1,         1'b0, 0};
        tbl[6] = '{1, 4'd6,  32'h0000_0F0F, 32'h0000_F000, 32'h0000_FF0F, 1'b0, 0};
        tbl[7] = '{0, 4'd7,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1'b0, 1};
        tbl[8] = '{1, 4'd5,  32'h8000_0000, 32'd31,        32'd1,         1'b0, 0};
        tbl[9] = '{0, 4'd15, 32'd1,         32'd1,         32'd0,         1'b1, 0};

        do_reset();
        drive(0, 4'd0, 32'd5, 32'd7);
        req_valid = 2'b01;
        wait_ready(w);
        check("mid_rst_grant", w, 0);
        @(posedge clk);
        #1 req_valid = '0;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_data", resp_data, 0);
        check("mid_rst_alu", {alu_a, alu_b} == '0, 1);
        check("mid_rst_flags", {resp_err, alu_op, req_ready, resp_valid}, 0);
        @(negedge clk);
        rst = 1'b0;
        any_resp = 1'b0;
        repeat (5) begin
            @(negedge clk);
            any_resp |= |resp_valid;
        end
        check("mid_rst_no_resp", any_resp, 0);
        @(posedge clk);
        #1 drive(0, 4'd0, 32'd1, 32'd1);
        req_valid = 2'b01;
        wait_ready(w);
        check("post_rst_grant", w, 0);
        finish_txn(w, 4'd0, 32'd2, 1'b0, 0, 2'b11);

        do_reset();
        foreach (tbl[k]) begin
            drive(tbl[k].idx, tbl[k].op, tbl[k].a, tbl[k].b);
            req_valid = 2'b01 << tbl[k].idx;
            wait_ready(w);
            check("tbl_grant", w, tbl[k].idx);
            finish_txn(w, tbl[k].op, tbl[k].d, tbl[k].e, tbl[k].hold, 2'b11);
        end

        do_reset();
        drive(0, 4'd0, 32'd1, 32'd2);
        drive(1, 4'd4, 32'hF0, 32'h0F);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_ready(w);
            check("rr_order", w, k % 2);
            finish_txn(w, w ? 4'd4 : 4'd0, w ? 32'hFF : 32'd3, 1'b0, 0, 2'b00);
        end
        req_valid = '0;

        drive(0, 4'd6, 32'd3, 32'd4);
        req_valid = 2'b01;
        wait_ready(w);
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        resp_ready = 2'b10;
        repeat (3) begin
            @(negedge clk);
            check("nonowner_hold", resp_valid, 2'b01);
            check("nonowner_data", resp_data, 7);
        end
        resp_ready = 2'b11;
        @(posedge clk);
        #1 resp_ready = '0;
        @(negedge clk);
        check("owner_release", resp_valid, 0);

        do_reset();
        last = 1;
        for (int n = 0; n < 40; n++) begin
            mask = 2'($urandom_range(1, 3));
            for (int i = 0; i < 2; i++) begin
                ops[i] = 4'($urandom_range(0, 15));
                as[i]  = $urandom;
                bs[i]  = $urandom_range(0, 1) ? 32'($urandom_range(0, 40)) : $urandom;
                drive(i, ops[i], as[i], bs[i]);
            end
            exp_w = -1;
            for (int d = 1; d <= 2; d++) if (exp_w < 0 && mask[(last + d) % 2]) exp_w = (last + d) % 2;
            req_valid = mask;
            wait_ready(w);
            check("rand_grant", w, exp_w);
            finish_txn(w, ops[w], legal(ops[w]) ? alu_f(as[w], bs[w], ops[w]) : 32'd0,
                       !legal(ops[w]), n % 3, 2'b11);
            last = exp_w;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
